// File: rtl/instr_encoder_pkg.sv
// Shared encodings for the RV32I immediate encoder and generator: kind codes, opcodes, NOP.
package instr_encoder_pkg;

    typedef enum logic [3:0] {
        KindI  = 4'd0,
        KindS  = 4'd1,
        KindSb = 4'd2,
        KindU  = 4'd3,
        KindUp = 4'd4,
        KindJ  = 4'd5,
        KindJr = 4'd6,
        KindL  = 4'd7,
        KindLi = 4'd8
    } kind_e;

    localparam logic [6:0] OpI     = 7'b0010011;
    localparam logic [6:0] OpS     = 7'b0100011;
    localparam logic [6:0] OpSb    = 7'b1100011;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpLoad  = 7'b0000011;

    localparam logic [31:0] Nop = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StEmit,
        StEmitHi,
        StEmitLo
    } state_e;

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational immediate range check and field scatter for one RV32I instruction word.
module imm_pack
    import instr_encoder_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    logic        sext12;
    logic        sext13;
    logic        sext21;
    logic [31:0] raw;
    logic        bad;

    assign sext12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign sext13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign sext21 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        raw = Nop;
        bad = 1'b1;
        case (kind)
            KindI: begin
                raw = {imm[11:0], rs1, funct3, rd, OpI};
                bad = !sext12;
            end
            KindL: begin
                raw = {imm[11:0], rs1, funct3, rd, OpLoad};
                bad = !sext12;
            end
            KindJr: begin
                raw = {imm[11:0], rs1, 3'b000, rd, OpJalr};
                bad = !sext12;
            end
            KindS: begin
                raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], OpS};
                bad = !sext12;
            end
            KindSb: begin
                raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OpSb};
                bad = !sext13 || imm[0];
            end
            KindU: begin
                raw = {imm[31:12], rd, OpLui};
                bad = |imm[11:0];
            end
            KindUp: begin
                raw = {imm[31:12], rd, OpAuipc};
                bad = |imm[11:0];
            end
            KindJ: begin
                raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpJal};
                bad = !sext21 || imm[0];
            end
            default: ;
        endcase
    end

    assign instr = bad ? Nop : raw;
    assign err   = bad;

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder with li expansion; registered output behind valid/ready.
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_kind,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic        out_last
);

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        err_q, err_d;
    logic        last_q, last_d;
    logic [4:0]  rd_q, rd_d;
    logic [11:0] lo_q, lo_d;

    logic        li_fits;
    logic        li_two;
    logic [19:0] hi20;
    logic        accept;

    logic [3:0]  p_kind;
    logic [4:0]  p_rd;
    logic [4:0]  p_rs1;
    logic [4:0]  p_rs2;
    logic [2:0]  p_funct3;
    logic [31:0] p_imm;
    logic [31:0] p_instr;
    logic        p_err;

    // hi20 absorbs the borrow that sign-extending lo takes out of the upper part.
    assign li_fits = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign hi20    = in_imm[31:12] + {19'd0, in_imm[11]};
    assign li_two  = (in_kind == KindLi) && !li_fits && (in_imm[11:0] != 12'd0);

    assign out_valid = (state_q != StIdle);
    assign in_ready  = (state_q == StIdle) ||
                       (((state_q == StEmit) || (state_q == StEmitLo)) && out_ready);
    assign accept    = in_valid && in_ready;

    // While EMIT_HI holds the LUI, the packer builds the pending ADDI from captured fields.
    always_comb begin
        p_kind   = in_kind;
        p_rd     = in_rd;
        p_rs1    = in_rs1;
        p_rs2    = in_rs2;
        p_funct3 = in_funct3;
        p_imm    = in_imm;
        if (state_q == StEmitHi) begin
            p_kind   = KindI;
            p_rd     = rd_q;
            p_rs1    = rd_q;
            p_rs2    = '0;
            p_funct3 = '0;
            p_imm    = {{20{lo_q[11]}}, lo_q};
        end else if (in_kind == KindLi) begin
            p_rs2    = '0;
            p_funct3 = '0;
            if (li_fits) begin
                p_kind = KindI;
                p_rs1  = '0;
            end else begin
                p_kind = KindU;
                p_imm  = {hi20, 12'd0};
            end
        end
    end

    imm_pack u_imm_pack (
        .kind   (p_kind),
        .rd     (p_rd),
        .rs1    (p_rs1),
        .rs2    (p_rs2),
        .funct3 (p_funct3),
        .imm    (p_imm),
        .instr  (p_instr),
        .err    (p_err)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        err_d   = err_q;
        last_d  = last_q;
        rd_d    = rd_q;
        lo_d    = lo_q;
        if (accept) begin
            state_d = li_two ? StEmitHi : StEmit;
            instr_d = p_instr;
            err_d   = p_err;
            last_d  = !li_two;
            rd_d    = in_rd;
            lo_d    = in_imm[11:0];
        end else if (out_valid && out_ready) begin
            if (state_q == StEmitHi) begin
                state_d = StEmitLo;
                instr_d = p_instr;
                err_d   = p_err;
                last_d  = 1'b1;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            instr_q <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            rd_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            lo_q    <= lo_d;
        end
    end

    assign out_instr = instr_q;
    assign out_err   = err_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, corner sequences, random scoreboard.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic        out_last;

    instr_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic        last;
    } word_t;

    typedef struct {
        logic [3:0]  kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        err;
    } vec_t;

    word_t exp_q[$];
    vec_t  vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit rng(input int s, input int bits);
        return (s >= -(1 << (bits - 1))) && (s < (1 << (bits - 1)));
    endfunction

    function automatic logic [31:0] fld(input logic [31:0] v, input int lsb, input int w,
                                        input int pos);
        return ((v >> lsb) & ((32'd1 << w) - 32'd1)) << pos;
    endfunction

    // Reference: expected words for one request, appended to exp_q.
    task automatic model(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
        int          s;
        int          lo;
        logic        ok;
        logic [31:0] r;
        logic [31:0] hi;
        logic [31:0] regs_i;
        logic [31:0] regs_s;
        s      = $signed(imm);
        ok     = 1'b0;
        r      = 32'h13;
        regs_i = (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
        regs_s = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
        if (k == 4'd8) begin
            if (rng(s, 12)) begin
                exp_q.push_back('{fld(imm, 0, 12, 20) | (32'(rd) << 7) | 32'h13, 1'b0, 1'b1});
            end else begin
                lo = ((s & 'hFFF) ^ 'h800) - 'h800;
                hi = imm - 32'(lo);
                exp_q.push_back('{(hi & 32'hFFFF_F000) | (32'(rd) << 7) | 32'h37, 1'b0,
                                  lo == 0});
                if (lo != 0)
                    exp_q.push_back('{fld(32'(lo), 0, 12, 20) | (32'(rd) << 15) |
                                      (32'(rd) << 7) | 32'h13, 1'b0, 1'b1});
            end
        end else begin
            case (k)
                4'd0: begin ok = rng(s, 12); r = fld(imm, 0, 12, 20) | regs_i | 32'h13; end
                4'd7: begin ok = rng(s, 12); r = fld(imm, 0, 12, 20) | regs_i | 32'h03; end
                4'd6: begin
                    ok = rng(s, 12);
                    r  = fld(imm, 0, 12, 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h67;
                end
                4'd1: begin
                    ok = rng(s, 12);
                    r  = fld(imm, 5, 7, 25) | regs_s | fld(imm, 0, 5, 7) | 32'h23;
                end
                4'd2: begin
                    ok = rng(s, 13) && (imm % 2 == 0);
                    r  = fld(imm, 12, 1, 31) | fld(imm, 5, 6, 25) | regs_s |
                         fld(imm, 1, 4, 8) | fld(imm, 11, 1, 7) | 32'h63;
                end
                4'd3, 4'd4: begin
                    ok = (imm % 4096 == 0);
                    r  = imm | (32'(rd) << 7) | ((k == 4'd3) ? 32'h37 : 32'h17);
                end
                4'd5: begin
                    ok = rng(s, 21) && (imm % 2 == 0);
                    r  = fld(imm, 20, 1, 31) | fld(imm, 1, 10, 21) | fld(imm, 11, 1, 20) |
                         fld(imm, 12, 8, 12) | (32'(rd) << 7) | 32'h6F;
                end
                default: ok = 1'b0;
            endcase
            exp_q.push_back('{ok ? r : 32'h13, !ok, 1'b1});
        end
    endtask

    task automatic drive(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
        in_kind   = k;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_imm    = imm;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(posedge clk); #1;
        drive(v.kind, v.rd, v.rs1, v.rs2, v.f3, v.imm);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check($sformatf("vec%0d in_ready", idx), in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int j = 0; j < v.n; j++) begin
            @(negedge clk);
            check($sformatf("vec%0d w%0d valid", idx, j), out_valid, 1);
            check($sformatf("vec%0d w%0d instr", idx, j), out_instr, (j == 0) ? v.w0 : v.w1);
            check($sformatf("vec%0d w%0d err", idx, j), out_err, v.err);
            check($sformatf("vec%0d w%0d last", idx, j), out_last, j == v.n - 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check($sformatf("vec%0d idle", idx), out_valid, 0);
    endtask

    initial begin
        word_t w;
        vecs[0]  = '{4'd1, 5'd0, 5'd2, 5'd6, 3'd2, 32'hFFFF_FFFC, 1, 32'hFE61_2E23, 32'h0, 1'b0};
        vecs[1]  = '{4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800, 1, 32'h0010_00EF, 32'h0, 1'b0};
        vecs[2]  = '{4'd2, 5'd0, 5'd1, 5'd2, 3'd0, 32'h0000_0003, 1, 32'h0000_0013, 32'h0, 1'b1};
        vecs[3]  = '{4'd8, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5FFF, 2, 32'h1234_62B7,
                     32'hFFF2_8293, 1'b0};
        vecs[4]  = '{4'd8, 5'd5, 5'd0, 5'd0, 3'd0, 32'h7FFF_F800, 2, 32'h8000_02B7,
                     32'h8002_8293, 1'b0};
        vecs[5]  = '{4'd8, 5'd5, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFB, 1, 32'hFFB0_0293, 32'h0, 1'b0};
        vecs[6]  = '{4'd0, 5'd1, 5'd2, 5'd0, 3'd0, 32'h0000_0005, 1, 32'h0051_0093, 32'h0, 1'b0};
        vecs[7]  = '{4'd0, 5'd1, 5'd2, 5'd0, 3'd0, 32'h0000_0800, 1, 32'h0000_0013, 32'h0, 1'b1};
        vecs[8]  = '{4'd6, 5'd1, 5'd5, 5'd0, 3'd7, 32'hFFFF_FFFC, 1, 32'hFFC2_80E7, 32'h0, 1'b0};
        vecs[9]  = '{4'd2, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFF8, 1, 32'hFE20_8CE3, 32'h0, 1'b0};
        vecs[10] = '{4'd8, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000, 1, 32'h1234_52B7, 32'h0, 1'b0};
        vecs[11] = '{4'd3, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5001, 1, 32'h0000_0013, 32'h0, 1'b1};
        vecs[12] = '{4'd9, 5'd5, 5'd1, 5'd2, 3'd0, 32'h0000_0000, 1, 32'h0000_0013, 32'h0, 1'b1};
        vecs[13] = '{4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0010_0000, 1, 32'h0000_0013, 32'h0, 1'b1};
        vecs[14] = '{4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFF0_0000, 1, 32'h8000_00EF, 32'h0, 1'b0};
        vecs[15] = '{4'd7, 5'd3, 5'd4, 5'd0, 3'd2, 32'hFFFF_F800, 1, 32'h8002_2183, 32'h0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0);

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst out_valid", out_valid, 0);
        check("rst out_instr", out_instr, 0);
        check("rst out_err", out_err, 0);
        check("rst out_last", out_last, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post-rst in_ready", in_ready, 1);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Back-to-back I requests: one word per cycle, in_ready stays high.
        exp_q.delete();
        for (int i = 0; i <= 4; i++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            if (i < 4) begin
                drive(4'd0, 5'(i + 1), 5'd3, 5'd0, 3'(i), 32'(i * 100 - 150));
                in_valid = 1'b1;
                model(4'd0, 5'(i + 1), 5'd3, 5'd0, 3'(i), 32'(i * 100 - 150));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 4) check($sformatf("b2b%0d in_ready", i), in_ready, 1);
            if (i > 0) begin
                w = exp_q.pop_front();
                check($sformatf("b2b%0d valid", i), out_valid, 1);
                check($sformatf("b2b%0d instr", i), out_instr, w.instr);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b idle", out_valid, 0);

        // Hold the LUI for 3 cycles while request inputs change underneath.
        @(posedge clk); #1;
        drive(4'd8, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5FFF);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drive(4'd8, 5'd9, 5'd0, 5'd0, 3'd0, 32'h0000_F0F0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("hold%0d instr", c), out_instr, 32'h1234_62B7);
            check($sformatf("hold%0d last", c), out_last, 0);
            check($sformatf("hold%0d in_ready", c), in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("hold rel instr", out_instr, 32'h1234_62B7);
        @(posedge clk); #1;
        @(negedge clk);
        check("hold addi instr", out_instr, 32'hFFF2_8293);
        check("hold addi last", out_last, 1);
        check("hold addi in_ready", in_ready, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("hold idle", out_valid, 0);

        // Reset while EMIT_HI holds: ADDI must never appear.
        @(posedge clk); #1;
        drive(4'd8, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5FFF);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rsthi lui", out_instr, 32'h1234_62B7);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rsthi valid", out_valid, 0);
        check("rsthi in_ready", in_ready, 1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("rsthi quiet%0d", c), out_valid, 0);
        end

        // Random traffic against the reference model.
        exp_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [31:0] imm;
            logic [3:0]  k;
            @(posedge clk); #1;
            k = ($urandom % 8 == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            case ($urandom % 4)
                0: imm = $urandom;
                1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                2: imm = $urandom & 32'hFFFF_F000;
                default: imm = 32'($urandom_range(0, 32'h3F_FFFF)) - 32'h20_0000;
            endcase
            drive(k, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), imm);
            in_valid  = ($urandom % 3 != 0);
            out_ready = ($urandom % 4 != 0);
            @(negedge clk);
            check("rnd valid", out_valid, exp_q.size() != 0);
            check("rnd in_ready", in_ready,
                  (exp_q.size() == 0) || ((exp_q.size() == 1) && out_ready));
            if (out_valid && exp_q.size() > 0) begin
                w = exp_q[0];
                check("rnd instr", out_instr, w.instr);
                check("rnd err", out_err, w.err);
                check("rnd last", out_last, w.last);
                if (out_ready) void'(exp_q.pop_front());
            end
            if (in_valid && in_ready)
                model(in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_imm);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid && exp_q.size() > 0) begin
                w = exp_q.pop_front();
                check("drain instr", out_instr, w.instr);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("drain empty", exp_q.size(), 0);
        check("drain idle", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RISC-V instruction encoder: the inverse of the immediate generator. Takes an instruction description (kind, register fields, funct3, full 32-bit immediate), range-checks the immediate, and scatters it into the RV32I immediate fields for that format. Also expands the `li` pseudo-instruction into `LUI`+`ADDI` when required. It sits between the program loader/debug front end and instruction-memory write port, with valid/ready handshakes on both sides.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  encoder can accept a request this cycle.
- `in_kind`  in  4  0 I, 1 S, 2 SB, 3 U (LUI), 4 UP (AUIPC), 5 J (JAL), 6 JR (JALR), 7 L (load), 8 LI; 9–15 illegal.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register fields; ignored where the format has none.
- `in_funct3`  in  3  funct3 for I/S/SB/L; ignored for JR (forced 000), U/UP/J/LI.
- `in_imm`  in  32  full immediate in two's complement, as the generator would reproduce it.
- `out_valid`  out  1  `out_instr` valid.
- `out_ready`  in  1  consumer accepts the word.
- `out_instr`  out  32  encoded instruction.
- `out_err`  out  1  qualifies `out_instr`: immediate out of range, misaligned, or kind illegal.
- `out_last`  out  1  final word for the current request.

## Operation
- Opcodes: I 0010011, S 0100011, SB 1100011, U 0110111, UP 0010111, J 1101111, JR 1100111, L 0000011.
- Field packing is the exact inverse of the generator, bit for bit:
  - I/JR/L: `imm[11:0]` in [31:20].
  - S: `imm[11:5]` in [31:25], `imm[4:0]` in [11:7].
  - SB: `imm[12|10:5]` in [31|30:25], `imm[4:1|11]` in [11:8|7].
  - U/UP: `imm[31:12]` in [31:12].
  - J: `imm[20|10:1|11|19:12]` in [31|30:21|20|19:12].
- Legality checks:
  - I/S/JR/L: `imm[31:11]` all equal.
  - SB: `imm[31:12]` all equal and `imm[0]`=0.
  - J: `imm[31:20]` all equal and `imm[0]`=0.
  - U/UP: `imm[11:0]`=0.
  - Illegal: kind 9–15.
  - On any violation, emit one word with `out_instr`=0x00000013 (NOP), `out_err`=1, `out_last`=1.
- LI:
  - `lo` = sign-extension of `imm[11:0]`.
  - `hi20` = `imm[31:12] + imm[11]`, modulo 2^20 (wraps, no error).
  - If `imm[31:11]` are all equal: one word, `ADDI rd,x0,lo`.
  - Else if `lo`=0: one word, `LUI rd,hi20`.
  - Else: two words, `LUI rd,hi20` then `ADDI rd,rd,lo`.
  - LI never errors.
- FSM states:
  - IDLE: output empty, `in_ready`=1.
  - EMIT: holding a final word.
  - EMIT_HI: holding LUI, with ADDI pending.
  - EMIT_LO: holding ADDI.
- Transitions:
  - IDLE + accept → EMIT, or EMIT_HI for a two-word LI.
  - EMIT_HI + out handshake → EMIT_LO.
  - EMIT / EMIT_LO + out handshake → IDLE, or directly to the next request's state if one is accepted in the same cycle.
- Request fields for a two-word LI (`rd`, `lo`) are captured at accept time; later input changes have no effect.

## Timing
- Reset values: `out_valid`=0, `out_instr`=0, `out_err`=0, `out_last`=0, state IDLE, `in_ready`=1 in the cycle after reset deasserts.
- Accept when `in_valid & in_ready` at a rising edge; `out_valid`=1 in the next cycle (latency 1).
- `in_ready` = IDLE | ((EMIT | EMIT_LO) & `out_ready`). Combinational from `out_ready`; no combinational path from `in_valid` to any output.
- A held word (`out_valid & !out_ready`) keeps `out_instr`, `out_err` and `out_last` stable.
- Throughput: one word per cycle under continuous `out_ready`, including back-to-back requests. A two-word LI occupies 2 output cycles and blocks input for 1 of them.
- `rst` mid-request (including between LUI and ADDI) drops all pending words; no partial sequence resumes.

## Structure
- Shared package (also imported by the generator):
  - kind codes 0–8;
  - the 8 opcode localparams;
  - NOP constant 0x00000013.
- Sub-module `imm_pack`: purely combinational `(kind, rd, rs1, rs2, funct3, imm)` → `(instr, err)`, reused for both LI words.
- FSM and output register live in the top module.

## Test plan
- S, `rs2`=6, `rs1`=2, `funct3`=2, `imm`=0xFFFFFFFC → single word 0xFE612E23, `err`=0, `last`=1, one cycle after accept.
- J, `rd`=1, `imm`=0x800 → 0x001000EF. SB with `imm`=3 → 0x00000013, `err`=1.
- LI, `rd`=5, `imm`=0x12345FFF → 0x123462B7 then 0xFFF28293, `last`=0 then 1. Hold `out_ready`=0 for 3 cycles on the first word; it stays stable.
- LI, `rd`=5, `imm`=0x7FFFF800 → `hi20` wraps to 0x80000: 0x800002B7 then 0x80028293. LI with `imm`=-5 → single 0xFFB00293.
- Back-to-back I requests with `out_ready`=1 → one word per cycle, `in_ready` never drops.
- Assert `rst` while EMIT_HI is holding → next cycle `out_valid`=0, `in_ready`=1, and no ADDI is ever emitted.
